// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, widths and key map for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int ROW_W = 2;
    localparam int COL_W = 2;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    // Indexed by {row, col}: rows top-down, columns left-right.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [3:0] key_code(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

    function automatic logic [ROW_W-1:0] low_index(input logic [ROWS-1:0] r);
        low_index = '0;
        for (int i = ROWS - 1; i >= 0; i--)
            if (!r[i]) low_index = ROW_W'(i);
    endfunction

endpackage

// File: rtl/keypad_scanner_sync.sv
// keypad_scanner_sync: two-flop synchronizer for the active-low keypad rows.
module keypad_scanner_sync
    import keypad_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [ROWS-1:0] d,
    output logic [ROWS-1:0] q
);

    logic [ROWS-1:0] meta;

    // Resets to all-high so an idle (pulled-up) keypad is seen immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scanning 4x4 keypad reader with debounced press and release.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows_async,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    state_t             state, state_nxt;
    logic [COL_W-1:0]   col, col_nxt;
    logic [ROW_W-1:0]   row, row_nxt;
    logic [DIV_W-1:0]   div, div_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [3:0]         key_nxt;
    logic               key_valid_nxt;
    logic [ROWS-1:0]    rs;
    logic [ROWS-1:0]    low;
    logic [ROWS-1:0]    pat;
    logic               tick;
    logic               single;
    logic               idle;
    logic               done;

    keypad_scanner_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows_async),
        .q     (rs)
    );

    assign tick     = div == DIV_W'(SCAN_DIV - 1);
    assign low      = ~rs;
    assign single   = (low != '0) && ((low & (low - ROWS'(1))) == '0);
    assign idle     = rs == '1;
    assign pat      = ~(ROWS'(1) << row);
    assign done     = cnt == CNT_W'(DEBOUNCE_CYCLES);
    assign cols     = ~(COLS'(1) << col);
    assign key_held = (state == HELD) || (state == RELEASE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            col       <= '0;
            row       <= '0;
            div       <= '0;
            cnt       <= '0;
            key       <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            row       <= row_nxt;
            div       <= div_nxt;
            cnt       <= cnt_nxt;
            key       <= key_nxt;
            key_valid <= key_valid_nxt;
        end
    end

    // The divider free-runs except when a release completes, which restarts it.
    always_comb begin
        state_nxt     = state;
        col_nxt       = col;
        row_nxt       = row;
        div_nxt       = tick ? '0 : div + DIV_W'(1);
        cnt_nxt       = cnt;
        key_nxt       = key;
        key_valid_nxt = 1'b0;
        case (state)
            SCAN: begin
                if (tick && single) begin
                    state_nxt = DEBOUNCE;
                    row_nxt   = low_index(rs);
                    cnt_nxt   = '0;
                end else if (tick) begin
                    col_nxt = col + COL_W'(1);
                end
            end
            DEBOUNCE: begin
                if (rs != pat) begin
                    state_nxt = SCAN;
                    cnt_nxt   = '0;
                end else if (done) begin
                    state_nxt     = HELD;
                    key_nxt       = key_code(row, col);
                    key_valid_nxt = 1'b1;
                    cnt_nxt       = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (idle) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end
            end
            RELEASE: begin
                if (!idle) begin
                    state_nxt = HELD;
                end else if (done) begin
                    state_nxt = SCAN;
                    col_nxt   = col + COL_W'(1);
                    div_nxt   = '0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = SCAN;
        endcase
    end

endmodule
